// File: rtl/dht22_pkg.sv
// Shared DHT22 constants: frame layout, plausibility limits, poll FSM encoding
// and the single-wire timing figures also used by the reader.
package dht22_pkg;

    localparam int FRAME_W      = 40;
    localparam int HUM_MSB      = 39;
    localparam int TEMP_MSB     = 23;
    localparam int SUM_MSB      = 7;

    localparam int HUM_MAX      = 1000;
    localparam int TEMP_POS_MAX = 800;
    localparam int TEMP_NEG_MAX = 400;

    // Bus timing in microseconds, kept here so the reader and poller agree
    localparam int T_HOST_START_LOW_US = 1000;
    localparam int T_HOST_RELEASE_US   = 30;
    localparam int T_BIT_ONE_MIN_US    = 50;
    localparam int T_MIN_POLL_US       = 2000000;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_TRIG,
        ST_SETTLE,
        ST_CAPTURE,
        ST_CHECK
    } state_t;

    function automatic logic [7:0] byte_sum(input logic [31:0] v);
        return v[31:24] + v[23:16] + v[15:8] + v[7:0];
    endfunction

endpackage

// File: rtl/dht22_poll_decoder_if.sv
// Reader-side and datapath-side signals of the poll decoder.
interface dht22_poll_decoder_if;
    import dht22_pkg::*;

    logic               dht_get;
    logic [FRAME_W-1:0] dht_data;
    logic [15:0]        humidity;
    logic [15:0]        temperature;
    logic               sample_valid;
    logic               data_ok;
    logic [7:0]         err_cnt;
    logic               stale;

    modport master (
        output dht_get, humidity, temperature, sample_valid, data_ok, err_cnt, stale,
        input  dht_data
    );

    modport slave (
        input  dht_get, humidity, temperature, sample_valid, data_ok, err_cnt, stale,
        output dht_data
    );

endinterface

// File: rtl/dht22_frame_check.sv
// Combinational validation of a DHT22 frame and conversion of its fields
// to RH x10 and signed degC x10.
module dht22_frame_check
    import dht22_pkg::*;
(
    input  logic [FRAME_W-1:0] frame,
    output logic               pass,
    output logic [15:0]        humidity,
    output logic [15:0]        temperature
);

    logic [15:0] hum_f;
    logic [15:0] temp_f;
    logic [7:0]  sum_f;
    logic [15:0] mag;
    logic        sum_ok;
    logic        hum_ok;
    logic        temp_ok;

    assign hum_f  = frame[HUM_MSB -: 16];
    assign temp_f = frame[TEMP_MSB -: 16];
    assign sum_f  = frame[SUM_MSB -: 8];
    assign mag    = {1'b0, temp_f[14:0]};

    assign sum_ok  = byte_sum({hum_f, temp_f}) == sum_f;
    assign hum_ok  = hum_f <= 16'(HUM_MAX);
    assign temp_ok = temp_f[15] ? (mag <= 16'(TEMP_NEG_MAX)) : (mag <= 16'(TEMP_POS_MAX));

    // An all-zero frame means the reader never completed a transfer
    assign pass = sum_ok && (|frame) && hum_ok && temp_ok;

    assign humidity    = hum_f;
    assign temperature = temp_f[15] ? (16'd0 - mag) : mag;

endmodule

// File: rtl/dht22_poll_decoder.sv
// Periodically triggers the DHT22 reader, captures its frame after a settle
// window and publishes validated samples plus error/stale status.
module dht22_poll_decoder
    import dht22_pkg::*;
#(
    parameter int POLL_PERIOD = 2000000,
    parameter int SETTLE      = 8000,
    parameter int FAIL_LIMIT  = 3,
    parameter int CNT_W       = 22
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  poll_en,
    dht22_poll_decoder_if.master  bus
);

    state_t             state_reg;
    logic [CNT_W-1:0]   period_cnt_reg;
    logic [CNT_W-1:0]   settle_cnt_reg;
    logic [FRAME_W-1:0] frame_q;
    logic               get_reg;
    logic [15:0]        hum_reg;
    logic [15:0]        temp_reg;
    logic               valid_reg;
    logic               ok_reg;
    logic [7:0]         err_reg;
    logic [7:0]         streak_reg;
    logic               stale_reg;

    logic               tick;
    logic               chk_pass;
    logic [15:0]        chk_hum;
    logic [15:0]        chk_temp;
    logic [7:0]         err_next;
    logic [7:0]         streak_next;

    dht22_frame_check u_check (
        .frame       (frame_q),
        .pass        (chk_pass),
        .humidity    (chk_hum),
        .temperature (chk_temp)
    );

    assign tick        = poll_en && (period_cnt_reg == CNT_W'(POLL_PERIOD - 1));
    assign err_next    = (err_reg == 8'hFF) ? err_reg : err_reg + 8'd1;
    assign streak_next = (streak_reg == 8'hFF) ? streak_reg : streak_reg + 8'd1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= ST_WAIT;
            period_cnt_reg <= '0;
            settle_cnt_reg <= '0;
            frame_q        <= '0;
            get_reg        <= 1'b1;
            hum_reg        <= '0;
            temp_reg       <= '0;
            valid_reg      <= 1'b0;
            ok_reg         <= 1'b0;
            err_reg        <= '0;
            streak_reg     <= '0;
            stale_reg      <= 1'b0;
        end else begin
            if (!poll_en || tick)
                period_cnt_reg <= '0;
            else
                period_cnt_reg <= period_cnt_reg + 1'b1;

            get_reg   <= 1'b1;
            valid_reg <= 1'b0;

            case (state_reg)
                ST_WAIT: begin
                    // get is registered, so it is low exactly while in TRIG
                    if (tick) begin
                        get_reg   <= 1'b0;
                        state_reg <= ST_TRIG;
                    end
                end
                ST_TRIG: begin
                    settle_cnt_reg <= '0;
                    state_reg      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt_reg == CNT_W'(SETTLE - 1))
                        state_reg <= ST_CAPTURE;
                    else
                        settle_cnt_reg <= settle_cnt_reg + 1'b1;
                end
                ST_CAPTURE: begin
                    frame_q   <= bus.dht_data;
                    state_reg <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (chk_pass) begin
                        hum_reg    <= chk_hum;
                        temp_reg   <= chk_temp;
                        valid_reg  <= 1'b1;
                        ok_reg     <= 1'b1;
                        streak_reg <= '0;
                        stale_reg  <= 1'b0;
                    end else begin
                        ok_reg     <= 1'b0;
                        err_reg    <= err_next;
                        streak_reg <= streak_next;
                        stale_reg  <= (streak_next >= 8'(FAIL_LIMIT));
                    end
                    state_reg <= ST_WAIT;
                end
                default: state_reg <= ST_WAIT;
            endcase
        end
    end

    assign bus.dht_get      = get_reg;
    assign bus.humidity     = hum_reg;
    assign bus.temperature  = temp_reg;
    assign bus.sample_valid = valid_reg;
    assign bus.data_ok      = ok_reg;
    assign bus.err_cnt      = err_reg;
    assign bus.stale        = stale_reg;

endmodule

// File: tb/tb_dht22_poll_decoder.sv
// Scoreboard bench: each observed trigger queues the frame on the bus; the
// expected outcome is derived from a reference model when the result is due.
module tb_dht22_poll_decoder;

    localparam int PP = 100;
    localparam int ST = 20;
    localparam int FL = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic poll_en = 1'b0;

    dht22_poll_decoder_if bus();

    dht22_poll_decoder #(
        .POLL_PERIOD (PP),
        .SETTLE      (ST),
        .FAIL_LIMIT  (FL),
        .CNT_W       (22)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .poll_en (poll_en),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [39:0] frame;
    } exp_t;

    exp_t sb[$];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   next_trig = -1;
    int   done_cnt = 0;
    logic prev_get = 1'b1;

    logic [15:0] m_hum;
    logic [15:0] m_temp;
    logic        m_ok;
    logic        m_stale;
    int          m_err;
    int          m_streak;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
        end
    endtask

    function automatic bit ref_pass(input logic [39:0] f, output logic [15:0] h, output logic [15:0] t);
        int hv;
        int tm;
        int s;
        bit neg;
        hv  = int'(f[39:24]);
        tm  = int'(f[22:8]);
        neg = f[23];
        s   = (int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256;
        h   = f[39:24];
        t   = neg ? 16'(-tm) : 16'(tm);
        return (s == int'(f[7:0])) && (f != 40'h0) && (hv <= 1000) && (neg ? (tm <= 400) : (tm <= 800));
    endfunction

    function automatic logic [39:0] mk_frame(input logic [15:0] h, input logic [15:0] t);
        logic [7:0] s;
        s = 8'(h[15:8] + h[7:0] + t[15:8] + t[7:0]);
        return {h, t, s};
    endfunction

    task automatic model_reset();
        m_hum = '0; m_temp = '0; m_ok = 1'b0; m_stale = 1'b0;
        m_err = 0; m_streak = 0;
        sb.delete();
        next_trig = -1;
    endtask

    task automatic step();
        exp_t e;
        logic [15:0] h;
        logic [15:0] t;
        bit ev;
        @(negedge clk);
        cyc++;
        if (reset) begin
            if (bus.dht_get == 1'b0) begin
                chk("get_width", 64'(prev_get), 64'(1));
                chk("trig_time", 64'(cyc), 64'(next_trig));
                if (next_trig >= 0) next_trig += PP;
                sb.push_back('{cyc + ST + 3, bus.dht_data});
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                if (ref_pass(e.frame, h, t)) begin
                    m_hum = h; m_temp = t; m_ok = 1'b1; m_streak = 0; m_stale = 1'b0; ev = 1'b1;
                end else begin
                    m_ok = 1'b0; ev = 1'b0;
                    if (m_err < 255) m_err++;
                    if (m_streak < 255) m_streak++;
                    m_stale = (m_streak >= FL);
                end
                $display("poll frame=%010h valid=%0b hum=%0d temp=%04h ok=%0b err=%0d stale=%0b",
                         e.frame, bus.sample_valid, bus.humidity, bus.temperature,
                         bus.data_ok, bus.err_cnt, bus.stale);
                chk("sample_valid", 64'(bus.sample_valid), 64'(ev));
                chk("humidity",     64'(bus.humidity),     64'(m_hum));
                chk("temperature",  64'(bus.temperature),  64'(m_temp));
                chk("data_ok",      64'(bus.data_ok),      64'(m_ok));
                chk("err_cnt",      64'(bus.err_cnt),      64'(m_err));
                chk("stale",        64'(bus.stale),        64'(m_stale));
                done_cnt++;
            end else if (bus.sample_valid) begin
                chk("spurious_valid", 64'(bus.sample_valid), 64'(0));
            end
        end
        prev_get = bus.dht_get;
    endtask

    task automatic wait_done();
        int start;
        start = done_cnt;
        for (int i = 0; i < 3 * PP; i++) begin
            step();
            if (done_cnt != start) return;
        end
        chk("poll_timeout", 64'(done_cnt), 64'(start + 1));
    endtask

    task automatic do_poll(input logic [39:0] f);
        bus.dht_data = f;
        wait_done();
    endtask

    task automatic check_reset_vals(input string tag);
        $display("reset check %s get=%0b hum=%0d temp=%04h", tag, bus.dht_get, bus.humidity, bus.temperature);
        chk({tag, "_get"},   64'(bus.dht_get),      64'(1));
        chk({tag, "_hum"},   64'(bus.humidity),     64'(0));
        chk({tag, "_temp"},  64'(bus.temperature),  64'(0));
        chk({tag, "_valid"}, 64'(bus.sample_valid), 64'(0));
        chk({tag, "_ok"},    64'(bus.data_ok),      64'(0));
        chk({tag, "_err"},   64'(bus.err_cnt),      64'(0));
        chk({tag, "_stale"}, 64'(bus.stale),        64'(0));
    endtask

    initial begin
        bus.dht_data = 40'h0;
        model_reset();
        repeat (3) step();
        check_reset_vals("rst0");

        // Release reset with polling already enabled
        bus.dht_data = 40'h028C015FEE;
        reset = 1'b1;
        poll_en = 1'b1;
        next_trig = cyc + PP;

        do_poll(40'h028C015FEE);
        do_poll(40'h028C806573);
        do_poll(40'h028C015FEE);
        do_poll(40'h028C015FEF);

        // Abort a poll mid-settle with reset, then drop poll_en
        begin : abort_blk
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 2 * PP && !seen; i++) begin
                step();
                if (bus.dht_get == 1'b0) seen = 1'b1;
            end
            chk("abort_trig_seen", 64'(seen), 64'(1));
        end
        repeat (5) step();
        reset = 1'b0;
        model_reset();
        step();
        chk("abort_get_high", 64'(bus.dht_get), 64'(1));
        poll_en = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        repeat (2) step();
        check_reset_vals("rst1");
        repeat (150) step();
        chk("idle_no_valid", 64'(bus.sample_valid), 64'(0));

        poll_en = 1'b1;
        next_trig = cyc + PP;
        repeat (3) do_poll(40'h0);
        do_poll(40'h028C015FEE);

        // Range boundaries and negative zero
        do_poll(mk_frame(16'd1000, 16'd800));
        do_poll(mk_frame(16'd1001, 16'd200));
        do_poll(mk_frame(16'd500, 16'h8000 | 16'd400));
        do_poll(mk_frame(16'd500, 16'd801));
        do_poll(mk_frame(16'd500, 16'h8000 | 16'd401));
        do_poll(mk_frame(16'd321, 16'h8000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
